vga_display_register_n: RTL

//  Draws a WIDTH-bit register as a row of "LED" rectangles at a fixed screen position, MSB leftmost.

---
 rtl/vga_display_register_n.sv | 104 ++++++++++
 1 files changed

// File: rtl/vga_display_register_n.sv
// Draws a WIDTH-bit register as a row of LED rectangles on the VGA raster, MSB leftmost.
// Data is sampled once per frame; bits that changed are highlighted for HOLD_FRAMES frames.
module vga_display_register_n #(
  parameter int          WIDTH          = 8,
  parameter int          START_H        = 10,
  parameter int          START_V        = 10,
  parameter int          W              = 26,
  parameter int          H              = 16,
  parameter int          WG             = 10,
  parameter int          HOLD_FRAMES    = 30,
  parameter logic [23:0] COLOUR_BG      = 24'hFFFFFF,
  parameter logic [23:0] COLOUR_ON      = 24'hFF0000,
  parameter logic [23:0] COLOUR_OFF     = 24'h444444,
  parameter logic [23:0] COLOUR_CHG_ON  = 24'hFFFF00,
  parameter logic [23:0] COLOUR_CHG_OFF = 24'h0000FF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [10:0]      vga_h,
  input  logic [10:0]      vga_v,
  output logic [23:0]      pixel_out,
  output logic             display_on
);

  localparam int          CW     = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int          P      = W + WG;
  localparam logic [10:0] H_LO   = 11'(START_H);
  localparam logic [10:0] H_HI   = 11'(START_H + WG + P * WIDTH);
  localparam logic [10:0] V_LO   = 11'(START_V);
  localparam logic [10:0] V_HI   = 11'(START_V + H);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_FRAMES);

  logic [WIDTH-1:0] r_snap;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic             r_primed;
  logic             r_zero_d;

  logic             w_zero;
  logic             w_tick;
  logic             w_in;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_cnz;
  logic             w_led;
  logic             w_bit;
  logic             w_chg;
  logic [23:0]      w_col;

  assign w_zero = (vga_h == 11'd0) && (vga_v == 11'd0);
  assign w_tick = w_zero && !r_zero_d;

  // Per-bit hit windows from constant bounds; bit i sits at LED position WIDTH-1-i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_led
    localparam logic [10:0] L_LO = 11'(START_H + WG + (WIDTH - 1 - i) * P);
    localparam logic [10:0] L_HI = 11'(START_H + WG + (WIDTH - 1 - i) * P + W);
    assign w_hit[i] = (vga_h >= L_LO) && (vga_h < L_HI);
    assign w_cnz[i] = (r_cnt[i] != '0);
  end

  assign w_in  = (vga_v >= V_LO) && (vga_v < V_HI) && (vga_h >= H_LO) && (vga_h < H_HI);
  assign w_led = |w_hit;
  assign w_bit = |(w_hit & r_snap);
  assign w_chg = |(w_hit & w_cnz);

  always_comb begin
    w_col = COLOUR_BG;
    if (w_in && w_led) begin
      if (w_chg) w_col = w_bit ? COLOUR_CHG_ON : COLOUR_CHG_OFF;
      else       w_col = w_bit ? COLOUR_ON : COLOUR_OFF;
    end
  end

  // Frame-start state: snapshot and hold counters change only on the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap   <= '0;
      r_primed <= 1'b0;
      r_zero_d <= 1'b0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_zero_d <= w_zero;
      if (w_tick) begin
        r_snap   <= data_in;
        r_primed <= 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          if (r_primed && (data_in[i] != r_snap[i])) r_cnt[i] <= RELOAD;
          else if (r_cnt[i] != '0)                  r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
    end
  end

  // Output register: one cycle behind the raster position.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out  <= COLOUR_BG;
      display_on <= 1'b0;
    end else begin
      pixel_out  <= w_col;
      display_on <= w_in;
    end
  end

endmodule
